gshare_predictor: RTL

- Global-history (gshare) branch direction predictor with a direct-mapped branch target buffer (BTB).
- Sits directly upstream of instruction fetch in the mips core. Each cycle it takes the fetch PC and supplies a taken/not-taken guess and the next-PC target.
- Trained by the resolve stage with the actual branch outcome.
- Also keeps a running count of direction mispredicts for performance runs.

---
 rtl/gshare_predictor_if.sv | 48 ++++
 rtl/gshare_predictor.sv | 110 +++++++++++
 2 files changed

// File: rtl/gshare_predictor_if.sv
// ---------------------------------------------------------------------------
// gshare_predictor_if
// Groups the fetch-side prediction signals and the resolve-side training
// signals of the gshare branch predictor.
//
// Signals:
//   fetch_pc         fetch PC of the current cycle (word aligned)
//   pred_taken       predicted direction
//   pred_target      predicted next PC
//   pred_ghr         history value used for this prediction
//   upd_valid        a conditional branch resolved this cycle
//   upd_pc           PC of the resolved branch
//   upd_ghr          pred_ghr snapshot taken when the branch was fetched
//   upd_taken        actual direction
//   upd_target       actual taken target
//   upd_pred_taken   direction that was predicted for the branch
//   mispredict_count direction mispredicts since reset
//
// Modports: master drives fetch/training (pipeline, bench),
//           slave is the predictor itself.
// ---------------------------------------------------------------------------
interface gshare_predictor_if #(
    parameter int GHR_BITS = 6
);
    logic [31:0]         fetch_pc;
    logic                pred_taken;
    logic [31:0]         pred_target;
    logic [GHR_BITS-1:0] pred_ghr;
    logic                upd_valid;
    logic [31:0]         upd_pc;
    logic [GHR_BITS-1:0] upd_ghr;
    logic                upd_taken;
    logic [31:0]         upd_target;
    logic                upd_pred_taken;
    logic [31:0]         mispredict_count;

    modport master (
        output fetch_pc, upd_valid, upd_pc, upd_ghr, upd_taken,
               upd_target, upd_pred_taken,
        input  pred_taken, pred_target, pred_ghr, mispredict_count
    );

    modport slave (
        input  fetch_pc, upd_valid, upd_pc, upd_ghr, upd_taken,
               upd_target, upd_pred_taken,
        output pred_taken, pred_target, pred_ghr, mispredict_count
    );
endinterface

// File: rtl/gshare_predictor.sv
// ---------------------------------------------------------------------------
// gshare_predictor
// Global-history (gshare) direction predictor with a direct-mapped BTB.
// Prediction is purely combinational from fetch_pc; training happens on the
// rising edge when upd_valid is high. A running mispredict counter is kept
// for performance runs.
//
// Ports:
//   clk    system clock, all state updates on the rising edge
//   reset  synchronous, active-high; upd_valid is ignored while high
//   bus    gshare_predictor_if.slave (fetch, prediction and training signals)
//
// Handshake: there is no backpressure. upd_valid alone qualifies the
// training signals for the cycle it is high; fetch_pc is consumed every cycle.
// ---------------------------------------------------------------------------
module gshare_predictor #(
    parameter int GHR_BITS     = 6,
    parameter int BTB_IDX_BITS = 4
) (
    input  logic               clk,
    input  logic               reset,
    gshare_predictor_if.slave  bus
);
    localparam int PHT_N = 1 << GHR_BITS;
    localparam int BTB_N = 1 << BTB_IDX_BITS;
    localparam int TAG_W = 30 - BTB_IDX_BITS;

    // State arrays
    logic [GHR_BITS-1:0] r_ghr;
    logic [1:0]          r_pht        [PHT_N];
    logic                r_btb_valid  [BTB_N];
    logic [TAG_W-1:0]    r_btb_tag    [BTB_N];
    logic [31:0]         r_btb_target [BTB_N];
    logic [31:0]         r_mispredict_count;

    // Prediction path
    logic [GHR_BITS-1:0]     w_pidx;
    logic [BTB_IDX_BITS-1:0] w_bidx;
    logic                    w_hit;
    logic                    w_taken;

    assign w_pidx  = bus.fetch_pc[GHR_BITS+1:2] ^ r_ghr;
    assign w_bidx  = bus.fetch_pc[BTB_IDX_BITS+1:2];
    assign w_hit   = r_btb_valid[w_bidx] &&
                     (r_btb_tag[w_bidx] == bus.fetch_pc[31:2+BTB_IDX_BITS]);
    // A strong PHT vote is useless without a target, so a BTB miss forces
    // a not-taken guess.
    assign w_taken = r_pht[w_pidx][1] & w_hit;

    assign bus.pred_taken       = w_taken;
    assign bus.pred_target      = w_taken ? r_btb_target[w_bidx]
                                          : bus.fetch_pc + 32'd4;
    assign bus.pred_ghr         = r_ghr;
    assign bus.mispredict_count = r_mispredict_count;

    // Training path: index with the history snapshot carried down the
    // pipeline, not the live GHR, so the same counter that made the
    // prediction is the one trained.
    logic [GHR_BITS-1:0]     w_uidx;
    logic [BTB_IDX_BITS-1:0] w_ubidx;
    logic [1:0]              w_pht_cur;
    logic [1:0]              w_pht_next;
    logic                    w_mispredict;

    assign w_uidx       = bus.upd_pc[GHR_BITS+1:2] ^ bus.upd_ghr;
    assign w_ubidx      = bus.upd_pc[BTB_IDX_BITS+1:2];
    assign w_pht_cur    = r_pht[w_uidx];
    assign w_mispredict = (bus.upd_pred_taken != bus.upd_taken) &&
                          (r_mispredict_count != 32'hFFFF_FFFF);

    always_comb begin
        w_pht_next = w_pht_cur;
        if (bus.upd_taken && (w_pht_cur != 2'b11)) begin
            w_pht_next = w_pht_cur + 2'd1;
        end else if (!bus.upd_taken && (w_pht_cur != 2'b00)) begin
            w_pht_next = w_pht_cur - 2'd1;
        end
    end

    // Resettable state: history, counters, BTB valid bits, mispredict count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ghr              <= '0;
            r_mispredict_count <= '0;
            for (int i = 0; i < PHT_N; i++) begin
                r_pht[i] <= 2'b01;
            end
            for (int i = 0; i < BTB_N; i++) begin
                r_btb_valid[i] <= 1'b0;
            end
        end else if (bus.upd_valid) begin
            r_pht[w_uidx] <= w_pht_next;
            r_ghr         <= {r_ghr[GHR_BITS-2:0], bus.upd_taken};
            if (bus.upd_taken) begin
                r_btb_valid[w_ubidx] <= 1'b1;
            end
            if (w_mispredict) begin
                r_mispredict_count <= r_mispredict_count + 32'd1;
            end
        end
    end

    // BTB payload needs no reset; it is qualified by the valid bit.
    always_ff @(posedge clk) begin
        if (!reset && bus.upd_valid && bus.upd_taken) begin
            r_btb_tag[w_ubidx]    <= bus.upd_pc[31:2+BTB_IDX_BITS];
            r_btb_target[w_ubidx] <= bus.upd_target;
        end
    end
endmodule
